// File: rtl/frame_gen_multitap.sv
// Multi-tap test-pattern frame generator: FVAL/LVAL/DVAL timing plus TAPS pixels per clock.
// Geometry, blanking, pattern and mode are latched on every entry into F2L.
module frame_gen_multitap #(
  parameter int TAPS       = 2,
  parameter int BPP        = 8,
  parameter int MAX_WIDTH  = 4096,
  parameter int MAX_HEIGHT = 4096,
  localparam int WW        = $clog2(MAX_WIDTH + 1),
  localparam int HW        = $clog2(MAX_HEIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [2:0]           sel,
  input  logic [WW-1:0]        cfg_width,
  input  logic [HW-1:0]        cfg_height,
  input  logic [15:0]          cfg_f2l,
  input  logic [15:0]          cfg_l2d,
  input  logic [15:0]          cfg_hblank,
  input  logic [15:0]          cfg_vblank,
  output logic                 fval,
  output logic                 lval,
  output logic                 dval,
  output logic [TAPS*BPP-1:0]  pix_data,
  output logic [15:0]          frame_cnt,
  output logic                 frame_done,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, F2L, LPRE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t              state, state_nxt;
  logic [15:0]         phase, beat, line, lfsr;
  logic [15:0]         lim_beats, lim_height, lim_f2l, lim_l2d, lim_hb, lim_vb;
  logic [2:0]          lat_sel;
  logic                lat_mode, en_prev;
  logic                start, fin, lfsr_fb;
  logic [WW-1:0]       beats_raw;
  logic [15:0]         beats_c, height_c, bx, x;
  logic [BPP-1:0]      v;
  logic [TAPS*BPP-1:0] pix_nxt;

  always_comb begin
    beats_raw = cfg_width / WW'(TAPS);
    beats_c   = (beats_raw == '0) ? 16'd1 : 16'(beats_raw);
    height_c  = (cfg_height == '0) ? 16'd1 : 16'(cfg_height);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && (!en_prev || !mode)) state_nxt = F2L;
      F2L:     if (phase == lim_f2l - 16'd1) state_nxt = (lim_l2d == '0) ? ACTIVE : LPRE;
      LPRE:    if (phase == lim_l2d - 16'd1) state_nxt = ACTIVE;
      ACTIVE:  if (beat == lim_beats - 16'd1)
                 state_nxt = (line == lim_height - 16'd1) ? VBLANK : HBLANK;
      HBLANK:  if (phase == lim_hb - 16'd1) state_nxt = (lim_l2d == '0) ? ACTIVE : LPRE;
      VBLANK:  if (phase == lim_vb - 16'd1) state_nxt = (!lat_mode && en) ? F2L : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start   = (state_nxt == F2L) && (state != F2L);
  assign fin     = (state == ACTIVE) && (state_nxt == VBLANK);
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Pixels are built for the beat about to be presented, so they register alongside dval.
  always_comb begin
    pix_nxt = '0;
    x       = '0;
    v       = '0;
    bx      = (state == ACTIVE) ? beat + 16'd1 : '0;
    if (state_nxt == ACTIVE) begin
      for (int unsigned t = 0; t < TAPS; t++) begin
        x = bx * 16'(TAPS) + 16'(t);
        case (lat_sel)
          3'd0:    v = '0;
          3'd1:    v = BPP'(x);
          3'd2:    v = BPP'(line);
          3'd3:    v = (x[3] ^ line[3]) ? '1 : '0;
          3'd4:    v = BPP'(frame_cnt);
          3'd5:    v = BPP'(lfsr) ^ BPP'(t);
          3'd6:    v = BPP'(x + line);
          default: v = '1;
        endcase
        pix_nxt[t*BPP +: BPP] = v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      phase      <= '0;
      beat       <= '0;
      line       <= '0;
      lfsr       <= 16'hACE1;
      en_prev    <= 1'b0;
      lim_beats  <= 16'd1;
      lim_height <= 16'd1;
      lim_f2l    <= 16'd1;
      lim_l2d    <= '0;
      lim_hb     <= 16'd1;
      lim_vb     <= 16'd1;
      lat_sel    <= '0;
      lat_mode   <= 1'b0;
      fval       <= 1'b0;
      lval       <= 1'b0;
      dval       <= 1'b0;
      pix_data   <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state   <= state_nxt;
      en_prev <= en;
      phase   <= (state_nxt != state) ? '0 : phase + 16'd1;
      beat    <= (state == ACTIVE && state_nxt == ACTIVE) ? beat + 16'd1 : '0;
      if (start)
        line <= '0;
      else if (state == ACTIVE && state_nxt != ACTIVE)
        line <= line + 16'd1;
      if (start)
        lfsr <= 16'hACE1;
      else if (state_nxt == ACTIVE)
        lfsr <= {lfsr_fb, lfsr[15:1]};
      if (start) begin
        lim_beats  <= beats_c;
        lim_height <= height_c;
        lim_f2l    <= (cfg_f2l == '0) ? 16'd1 : cfg_f2l;
        lim_l2d    <= cfg_l2d;
        lim_hb     <= (cfg_hblank == '0) ? 16'd1 : cfg_hblank;
        lim_vb     <= (cfg_vblank == '0) ? 16'd1 : cfg_vblank;
        lat_sel    <= sel;
        lat_mode   <= mode;
      end
      fval       <= state_nxt inside {F2L, LPRE, ACTIVE, HBLANK};
      lval       <= state_nxt inside {LPRE, ACTIVE};
      dval       <= (state_nxt == ACTIVE);
      pix_data   <= pix_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= fin;
      if (fin) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_gen_multitap.sv
// Bench for frame_gen_multitap: per-frame expected waveforms are queued from the configuration
// and compared cycle by cycle; a table of configurations drives the main loop.
module tb_frame_gen_multitap;
  localparam int TAPS = 2;
  localparam int BPP  = 8;
  localparam int PW   = TAPS * BPP;
  localparam int WW   = $clog2(4096 + 1);
  localparam int HW   = $clog2(4096 + 1);

  logic          clk = 1'b0;
  logic          rst, en, mode;
  logic [2:0]    sel;
  logic [WW-1:0] cfg_width;
  logic [HW-1:0] cfg_height;
  logic [15:0]   cfg_f2l, cfg_l2d, cfg_hblank, cfg_vblank;
  logic          fval, lval, dval, frame_done, busy;
  logic [PW-1:0] pix_data;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_gen_multitap #(.TAPS(TAPS), .BPP(BPP), .MAX_WIDTH(4096), .MAX_HEIGHT(4096)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_f2l(cfg_f2l), .cfg_l2d(cfg_l2d),
    .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank),
    .fval(fval), .lval(lval), .dval(dval), .pix_data(pix_data),
    .frame_cnt(frame_cnt), .frame_done(frame_done), .busy(busy)
  );

  typedef struct packed {
    logic fval, lval, dval, done, busy;
    logic [15:0] fc;
    logic [PW-1:0] pix;
  } obs_t;

  typedef struct {
    logic [2:0] sel;
    int w, h, f2l, l2d, hb, vb;
    int period, fhi;
    bit chk_pix;
    logic [PW-1:0] pix0;
  } case_t;

  obs_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] fc_exp;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic int clamp1(input int a);
    return (a == 0) ? 1 : a;
  endfunction

  function automatic obs_t mk(input logic f, input logic l, input logic d, input logic dn,
                              input logic bz, input logic [15:0] fc, input logic [PW-1:0] p);
    obs_t o;
    o.fval = f; o.lval = l; o.dval = d; o.done = dn; o.busy = bz; o.fc = fc; o.pix = p;
    return o;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [PW-1:0] exp_pix(input logic [2:0] s, input int b, input int y,
                                            input logic [15:0] fc, input logic [15:0] lf);
    logic [PW-1:0] r;
    logic [31:0] v;
    int x;
    r = '0;
    for (int t = 0; t < TAPS; t++) begin
      x = b * TAPS + t;
      case (s)
        3'd0:    v = 0;
        3'd1:    v = x;
        3'd2:    v = y;
        3'd3:    v = (((x / 8) + (y / 8)) % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
        3'd4:    v = {16'h0, fc};
        3'd5:    v = {16'h0, lf} ^ t;
        3'd6:    v = x + y;
        default: v = 32'hFFFF_FFFF;
      endcase
      r[t*BPP +: BPP] = v[BPP-1:0];
    end
    return r;
  endfunction

  task automatic apply(input case_t c);
    sel        = c.sel;
    cfg_width  = WW'(c.w);
    cfg_height = HW'(c.h);
    cfg_f2l    = 16'(c.f2l);
    cfg_l2d    = 16'(c.l2d);
    cfg_hblank = 16'(c.hb);
    cfg_vblank = 16'(c.vb);
  endtask

  // Expected outputs for one frame, from the first FVAL-high cycle to the last VBLANK cycle.
  task automatic push_frame(input case_t c, input logic [15:0] fc);
    int nb, nh;
    logic [15:0] lf;
    nb = clamp1(c.w / TAPS);
    nh = clamp1(c.h);
    lf = 16'hACE1;
    repeat (clamp1(c.f2l)) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, fc, '0));
    for (int y = 0; y < nh; y++) begin
      repeat (c.l2d) q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, fc, '0));
      for (int b = 0; b < nb; b++) begin
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, fc, exp_pix(c.sel, b, y, fc, lf)));
        lf = lfsr_step(lf);
      end
      if (y < nh - 1)
        repeat (clamp1(c.hb)) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, fc, '0));
    end
    for (int k = 0; k < clamp1(c.vb); k++)
      q.push_back(mk(1'b0, 1'b0, 1'b0, k == 0, 1'b1, fc + 16'd1, '0));
  endtask

  // act 1: drop en after entry act_at; act 2: change cfg_width to 16 after entry act_at.
  task automatic check_frame(input string nm, input int act_at, input int act,
                             output int gap, output int done_at, output int fhi,
                             output logic [PW-1:0] pix0);
    obs_t e, a;
    int k;
    bit started, got;
    gap = 0; done_at = -1; fhi = 0; pix0 = '0; started = 1'b0; got = 1'b0; k = 0;
    while (!started && gap < 2000) begin
      @(negedge clk);
      gap++;
      if (fval === 1'b1) started = 1'b1;
    end
    chk({nm, "_start"}, 64'(started), 64'(1));
    if (!started) begin
      q.delete();
      return;
    end
    while (q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = q.pop_front();
      a = mk(fval, lval, dval, frame_done, busy, frame_cnt, pix_data);
      chk($sformatf("%s_cyc%0d", nm, k), 64'(a), 64'(e));
      if (fval) fhi++;
      if (frame_done && done_at < 0) done_at = cyc;
      if (dval && !got) begin
        pix0 = pix_data;
        got  = 1'b1;
      end
      if (k == act_at) begin
        if (act == 1) en = 1'b0;
        else cfg_width = WW'(16);
      end
      k++;
    end
  endtask

  initial begin
    case_t tab[8];
    case_t c;
    int gap, d_a, d_b, fhi, act_at, hi, k;
    logic [PW-1:0] p0;

    tab[0] = '{3'd1,  8,  3, 2, 1, 3, 4,  27,  23, 1'b1, 16'h0100};
    tab[1] = '{3'd2,  8,  3, 2, 1, 3, 4,  27,  23, 1'b1, 16'h0000};
    tab[2] = '{3'd3, 32, 10, 1, 0, 1, 2, 172, 170, 1'b1, 16'h0000};
    tab[3] = '{3'd4,  8,  2, 1, 2, 1, 1,  15,  14, 1'b0, 16'h0000};
    tab[4] = '{3'd5,  6,  2, 3, 1, 2, 3,  16,  13, 1'b1, 16'hE0E1};
    tab[5] = '{3'd6, 10,  4, 1, 1, 1, 1,  29,  28, 1'b1, 16'h0100};
    tab[6] = '{3'd7,  7,  1, 1, 0, 5, 1,   5,   4, 1'b1, 16'hFFFF};
    tab[7] = '{3'd0,  1,  0, 0, 0, 0, 0,   3,   2, 1'b1, 16'h0000};

    rst = 1'b0; en = 1'b1; mode = 1'b0;
    apply(tab[0]);
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({fval, lval, dval, busy, frame_done, frame_cnt, pix_data}), 64'(0));
    rst = 1'b1; en = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_hold", 64'({fval, busy}), 64'(0));
    fc_exp = '0;

    for (int i = 0; i < 8; i++) begin
      c = tab[i];
      apply(c);
      mode = 1'b0; en = 1'b1;
      push_frame(c, fc_exp);
      check_frame($sformatf("case%0d_a", i), -1, 0, gap, d_a, fhi, p0);
      fc_exp = fc_exp + 16'd1;
      chk($sformatf("case%0d_gap_a", i), 64'(gap), 64'(1));
      chk($sformatf("case%0d_fval_hi", i), 64'(fhi), 64'(c.fhi));
      if (c.chk_pix) chk($sformatf("case%0d_pix0", i), 64'(p0), 64'(c.pix0));
      act_at = (clamp1(c.h) > 1) ?
               clamp1(c.f2l) + c.l2d + clamp1(c.w / TAPS) + clamp1(c.hb) + 1 : 0;
      push_frame(c, fc_exp);
      check_frame($sformatf("case%0d_b", i), act_at, 1, gap, d_b, fhi, p0);
      fc_exp = fc_exp + 16'd1;
      chk($sformatf("case%0d_gap_b", i), 64'(gap), 64'(1));
      chk($sformatf("case%0d_period", i), 64'(d_b - d_a), 64'(c.period));
      @(negedge clk);
      chk($sformatf("case%0d_idle", i), 64'({fval, busy}), 64'(0));
      chk($sformatf("case%0d_fcnt", i), 64'(frame_cnt), 64'(fc_exp));
    end

    c = tab[0];
    apply(c);
    mode = 1'b1; en = 1'b1;
    push_frame(c, fc_exp);
    check_frame("single", -1, 0, gap, d_a, fhi, p0);
    fc_exp = fc_exp + 16'd1;
    chk("single_gap", 64'(gap), 64'(1));
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (fval || busy) hi++;
    end
    chk("single_no_retrigger", 64'(hi), 64'(0));
    chk("single_fcnt", 64'(frame_cnt), 64'(fc_exp));

    en = 1'b0;
    @(negedge clk);
    c = tab[0];
    apply(c);
    mode = 1'b0; en = 1'b1;
    push_frame(c, fc_exp);
    check_frame("cfgchg_a", 3, 2, gap, d_a, fhi, p0);
    fc_exp = fc_exp + 16'd1;
    c.w = 16;
    push_frame(c, fc_exp);
    check_frame("cfgchg_b", 5, 1, gap, d_b, fhi, p0);
    fc_exp = fc_exp + 16'd1;
    chk("cfgchg_gap_b", 64'(gap), 64'(1));
    chk("cfgchg_period", 64'(d_b - d_a), 64'(39));
    @(negedge clk);
    chk("cfgchg_idle", 64'({fval, busy}), 64'(0));

    c = tab[0];
    apply(c);
    mode = 1'b0; en = 1'b1;
    k = 0;
    while (k < 200 && dval !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_active", 64'(dval), 64'(1));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", 64'({fval, lval, dval, busy, frame_done, frame_cnt, pix_data}), 64'(0));
    rst = 1'b1; en = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_idle", 64'({fval, busy}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
